fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-register front fetch stage.
- Buffers up to DEPTH fetched {address, instruction} pairs between instruction memory and decode, with valid/ready handshakes on both sides.
- On a jump redirect it flushes all buffered entries and loads the redirect-target instruction as the sole entry.
- It also presents the next sequential fetch address (target + INST_BYTES) to the fetch logic.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, instruction address width in bits.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- INST_BYTES, 4, address increment applied to the redirect target.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid_i  in  1  upstream fetch data valid.
- in_ready_o  out  1  queue can accept an upstream entry this cycle.
- in_inst_i  in  DATA_W  fetched instruction.
- in_addr_i  in  ADDR_W  address of in_inst_i.
- redirect_i  in  1  jump taken; flush and reload.
- redirect_addr_i  in  ADDR_W  jump target address.
- redirect_inst_i  in  DATA_W  instruction at the jump target, supplied in the same cycle.
- redirect_fetch_addr_o  out  ADDR_W  next sequential fetch address after the redirect.
- out_valid_o  out  1  head entry valid toward decode.
- out_ready_i  in  1  decode accepts the head entry.
- out_inst_o  out  DATA_W  head instruction.
- out_addr_o  out  ADDR_W  head address.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - rd/wr pointers and count clear to 0.
  - Storage is not reset.
  - Resulting outputs: out_valid_o=0, out_inst_o=0, out_addr_o=0, count_o=0, in_ready_o=1 (provided redirect_i=0).
- Reset asserted mid-operation discards all entries at that edge. Reset wins over redirect, push and pop.
- Combinational outputs:
  - in_ready_o = (count != DEPTH) && !redirect_i. There is no combinational path from out_ready_i.
  - out_valid_o = (count != 0).
  - out_inst_o and out_addr_o show the head entry when count != 0. They are forced to 0 when count == 0.
  - redirect_fetch_addr_o = redirect_i ? redirect_addr_i + INST_BYTES (mod 2^ADDR_W, truncated to ADDR_W) : 0.
- Handshake events:
  - push = in_valid_i && in_ready_o.
  - pop = out_valid_o && out_ready_i.
- Normal cycle (redirect_i=0):
  - push writes {in_addr_i, in_inst_i} at wr_ptr; wr_ptr advances by 1, wrapping modulo DEPTH.
  - pop advances rd_ptr by 1, wrapping modulo DEPTH.
  - count becomes count + push − pop.
- Simultaneous push and pop:
  - When full: push is impossible (in_ready_o=0), so pop only and count becomes DEPTH−1.
  - When empty: pop is impossible, so push only and count becomes 1.
  - Otherwise both occur and count is unchanged.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass from in_* to out_*.
- Redirect cycle (redirect_i=1, reset_n=1):
  - Highest priority after reset.
  - All buffered entries are discarded.
  - The upstream push is blocked (in_ready_o=0).
  - A pop handshake in that cycle is void; decode must treat the head as killed.
  - At the edge: entry 0 ← {redirect_addr_i, redirect_inst_i}, rd_ptr=0, wr_ptr=1, count=1.
  - Next cycle: out_valid_o=1 with out_addr_o=redirect_addr_i.
- Back-to-back redirects: each one reloads, so the last redirect wins and count stays 1.
- Address wrap: redirect_addr_i = 2^ADDR_W − INST_BYTES gives redirect_fetch_addr_o = 0.
- Downstream stall: out_* stay stable while out_valid_o && !out_ready_i, unless a redirect or reset occurs.

Decomposition:
- Shared package fetch_pkg holds:
  - default DATA_W, ADDR_W and INST_BYTES constants;
  - a packed typedef fetch_entry_t {addr, inst}.
- One natural sub-module: fetch_queue_mem, a DEPTH×entry register array with one write port and one async read port.
- Pointer, count and redirect control stay in fetch_queue.

Test Plan:
1. Reset then idle: hold reset_n=0 for 2 cycles, release → count_o=0, out_valid_o=0, out_inst_o=0, in_ready_o=1.
2. Fill to full, no pop: push addrs 0x100, 0x104, 0x108, 0x10C with out_ready_i=0 → count_o=4, in_ready_o=0, out_addr_o=0x100; a fifth push is not accepted.
3. Drain in order: from the full state, set out_ready_i=1 for 4 cycles → out_addr_o = 0x100, 0x104, 0x108, 0x10C in successive cycles; then count_o=0 and out_valid_o=0.
4. Simultaneous push/pop at count 2 for 6 cycles with rd/wr pointers crossing the wrap point → count_o stays 2 and FIFO order is preserved.
5. Redirect at count 3 with an active push and pop, redirect_addr_i=0x2000, redirect_inst_i=0x00000013:
   - same cycle: redirect_fetch_addr_o=0x2004, in_ready_o=0;
   - next cycle: count_o=1, out_addr_o=0x2000, out_inst_o=0x00000013.
6. Wrap and reset mid-redirect:
   - redirect_addr_i=0xFFFFFFFC → redirect_fetch_addr_o=0x00000000;
   - reset_n=0 in the same cycle as redirect_i=1 → count_o=0 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-queue defaults and entry layout.
// Entries pair an instruction with the address it was fetched from.
package fetch_pkg;

    localparam int FETCH_DATA_W     = 32;
    localparam int FETCH_ADDR_W     = 32;
    localparam int FETCH_INST_BYTES = 4;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries, one write port, async read.
// Contents are intentionally not reset.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int W     = FETCH_ADDR_W + FETCH_DATA_W,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between instruction memory and decode.
// A redirect flushes everything and reloads the jump target as the only entry.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W     = FETCH_DATA_W,
    parameter int ADDR_W     = FETCH_ADDR_W,
    parameter int DEPTH      = 4,
    parameter int INST_BYTES = FETCH_INST_BYTES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_inst_i,
    input  logic [ADDR_W-1:0]          in_addr_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_addr_i,
    input  logic [DATA_W-1:0]          redirect_inst_i,
    output logic [ADDR_W-1:0]          redirect_fetch_addr_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_inst_o,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = ADDR_W + DATA_W;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          we;
    logic [PW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;

    assign in_ready_o  = (count != CW'(DEPTH)) && !redirect_i;
    assign out_valid_o = (count != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // The redirect target always lands in slot 0.
    assign we    = redirect_i || push;
    assign waddr = redirect_i ? '0 : wr_ptr;
    assign wdata = redirect_i ? {redirect_addr_i, redirect_inst_i}
                              : {in_addr_i, in_inst_i};

    fetch_queue_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(1);
            count  <= CW'(1);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign out_addr_o = out_valid_o ? rdata[W-1:DATA_W] : '0;
    assign out_inst_o = out_valid_o ? rdata[DATA_W-1:0] : '0;
    assign count_o    = count;

    assign redirect_fetch_addr_o = redirect_i
        ? redirect_addr_i + ADDR_W'(INST_BYTES) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_inst_i;
    logic [31:0] in_addr_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic [31:0] redirect_inst_i;
    logic [31:0] redirect_fetch_addr_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_inst_o;
    logic [31:0] out_addr_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    fetch_entry_t model_q[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .in_valid_i            (in_valid_i),
        .in_ready_o            (in_ready_o),
        .in_inst_i             (in_inst_i),
        .in_addr_i             (in_addr_i),
        .redirect_i            (redirect_i),
        .redirect_addr_i       (redirect_addr_i),
        .redirect_inst_i       (redirect_inst_i),
        .redirect_fetch_addr_o (redirect_fetch_addr_o),
        .out_valid_o           (out_valid_o),
        .out_ready_i           (out_ready_i),
        .out_inst_o            (out_inst_o),
        .out_addr_o            (out_addr_o),
        .count_o               (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs, advance model at the edge.
    task automatic step(input logic rst, input logic iv,
                        input logic [31:0] ia, input logic [31:0] ii,
                        input logic rd, input logic [31:0] ra,
                        input logic [31:0] ri, input logic ordy,
                        input logic en);
        int n;
        fetch_entry_t e;
        logic [31:0] exp_fa;
        reset_n         = rst;
        in_valid_i      = iv;
        in_addr_i       = ia;
        in_inst_i       = ii;
        redirect_i      = rd;
        redirect_addr_i = ra;
        redirect_inst_i = ri;
        out_ready_i     = ordy;
        #1;
        n      = model_q.size();
        exp_fa = rd ? ra + 32'd4 : 32'd0;
        if (en) begin
            chk("count", 64'(count_o), 64'(n));
            chk("out_valid", 64'(out_valid_o), 64'(n != 0));
            chk("out_addr", 64'(out_addr_o),
                n != 0 ? 64'(model_q[0].addr) : 64'd0);
            chk("out_inst", 64'(out_inst_o),
                n != 0 ? 64'(model_q[0].inst) : 64'd0);
            chk("in_ready", 64'(in_ready_o),
                64'((n != DEPTH) && !rd));
            chk("fetch_addr", 64'(redirect_fetch_addr_o), 64'(exp_fa));
        end
        if (!rst) begin
            model_q.delete();
        end else if (rd) begin
            model_q.delete();
            e.addr = ra;
            e.inst = ri;
            model_q.push_back(e);
        end else begin
            if (ordy && n != 0) begin
                e = model_q.pop_front();
            end
            if (iv && n < DEPTH) begin
                e.addr = ia;
                e.inst = ii;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic ordy);
        step(1, 1, a, $urandom, 0, 0, 0, ordy, 1);
    endtask

    task automatic idle(input logic ordy);
        step(1, 0, 0, 0, 0, 0, 0, ordy, 1);
    endtask

    initial begin
        @(negedge clk);
        // Reset then idle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        // Fill to full, then a rejected fifth push
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 0);
        push(32'h110, 0);
        idle(0);
        // Drain in order
        for (int i = 0; i < 4; i++) idle(1);
        idle(0);
        // Push/pop at count 2 across the pointer wrap
        push(32'h200, 0);
        push(32'h204, 0);
        for (int i = 0; i < 6; i++) push(32'h208 + 32'(4 * i), 1);
        idle(0);
        // Redirect at count 3 with active push and pop
        push(32'h300, 0);
        step(1, 1, 32'h400, 32'h1, 1, 32'h2000, 32'h13, 1, 1);
        idle(0);
        // Address wrap, then reset together with redirect
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hABCD, 0, 1);
        idle(0);
        step(0, 1, 32'h500, 0, 1, 32'h3000, 32'h7, 1, 1);
        idle(0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) != 0), $urandom_range(1),
                 $urandom & 32'hFFFF_FFFC, $urandom,
                 ($urandom_range(15) == 0),
                 ($urandom_range(7) == 0) ? 32'hFFFF_FFFC
                                          : ($urandom & 32'hFFFF_FFFC),
                 $urandom, $urandom_range(1), 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
